// File: rtl/alu_mul_seq.sv
// Sequential shift-and-add multiplier that borrows the shared combinational alu for every
// add and shift. It returns the low 32 bits of op_a*op_b over valid/ready handshakes.
module alu_mul_seq #(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  output logic [2:0]  alu_ALUOp,
  input  logic [31:0] alu_C,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res
);

  typedef enum logic [2:0] {IDLE, ADD, DBL, SHR, DONE} state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SRL = 3'd4;

  state_t      state, state_nxt;
  logic [31:0] acc, acc_nxt;
  logic [31:0] m, m_nxt;
  logic [31:0] q, q_nxt;
  logic [4:0]  cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      acc   <= '0;
      m     <= '0;
      q     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      m     <= m_nxt;
      q     <= q_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // m doubles each iteration (m+m) and q shifts right.
  // acc picks up m whenever the multiplier bit now at q[0] is set.
  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    m_nxt       = m;
    q_nxt       = q;
    cnt_nxt     = cnt;
    alu_A       = '0;
    alu_B       = '0;
    alu_ALUOp   = OP_ADD;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    res         = '0;

    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          acc_nxt = '0;
          m_nxt   = op_a;
          q_nxt   = op_b;
          cnt_nxt = '0;
          if (EARLY_EXIT && (op_b == '0))
            state_nxt = DONE;
          else if (op_b[0])
            state_nxt = ADD;
          else
            state_nxt = DBL;
        end
      end
      ADD: begin
        alu_A     = acc;
        alu_B     = m;
        acc_nxt   = alu_C;
        state_nxt = DBL;
      end
      DBL: begin
        alu_A     = m;
        alu_B     = m;
        m_nxt     = alu_C;
        state_nxt = SHR;
      end
      SHR: begin
        alu_A     = q;
        alu_B     = 32'd1;
        alu_ALUOp = OP_SRL;
        q_nxt     = alu_C;
        cnt_nxt   = cnt + 5'd1;
        if ((cnt == 5'd31) || (EARLY_EXIT && (alu_C == '0)))
          state_nxt = DONE;
        else if (alu_C[0])
          state_nxt = ADD;
        else
          state_nxt = DBL;
      end
      DONE: begin
        res_valid = 1'b1;
        res       = acc;
        if (res_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
